// File: rtl/jtag_tap_slave_if.sv
// Purpose : JTAG pins and the parallel user/debug signals of the
//           jtag_tap_slave, bundled so both ends share one declaration.
// Signals : TCK/TMS/TDI  JTAG pins driven by the master (probe side)
//           USER_IN      16-bit value captured into the USER data register
//           TDO/TDO_OE   serial data out and its valid qualifier
//           USER_OUT     USER register value latched at Update-DR
//           UPDATE_STB   one-FASTCLK pulse when USER_OUT is loaded
//           TAP_STATE    current TAP state code
//           IR_Q         active instruction
interface jtag_tap_slave_if #(
  parameter int IR_WIDTH = 8
);
  logic                TCK;
  logic                TMS;
  logic                TDI;
  logic [15:0]         USER_IN;
  logic                TDO;
  logic                TDO_OE;
  logic [15:0]         USER_OUT;
  logic                UPDATE_STB;
  logic [3:0]          TAP_STATE;
  logic [IR_WIDTH-1:0] IR_Q;

  modport master (
    output TCK, TMS, TDI, USER_IN,
    input  TDO, TDO_OE, USER_OUT, UPDATE_STB, TAP_STATE, IR_Q
  );

  modport slave (
    input  TCK, TMS, TDI, USER_IN,
    output TDO, TDO_OE, USER_OUT, UPDATE_STB, TAP_STATE, IR_Q
  );
endinterface

// File: rtl/jtag_tap_slave.sv
// Purpose : IEEE 1149.1 TAP controller running entirely in the FASTCLK
//           domain. TCK/TMS/TDI are oversampled through 2-flop
//           synchronizers and TCK edges are detected as data. Supports
//           IDCODE (32-bit DR), USER (16-bit DR) and BYPASS (1-bit DR).
// Ports   : FASTCLK  sole clock, all flops rising edge
//           RST_B    asynchronous active-low reset
//           bus      jtag_tap_slave_if.slave (JTAG pins, USER_IN/OUT,
//                    UPDATE_STB, TAP_STATE, IR_Q)
// Params  : IR_WIDTH instruction length (>=2), IDCODE capture value,
//           TMR      1 = every flop triplicated with majority vote
module jtag_tap_slave #(
  parameter int          IR_WIDTH = 8,
  parameter logic [31:0] IDCODE   = 32'h0DB70001,
  parameter bit          TMR      = 1'b0
) (
  input  logic              FASTCLK,
  input  logic              RST_B,
  jtag_tap_slave_if.slave   bus
);

  typedef enum logic [3:0] {
    TLR   = 4'hF, RTI   = 4'hC,
    SELDR = 4'h7, CAPDR = 4'h6, SHDR  = 4'h2, EX1DR = 4'h1,
    PAUDR = 4'h3, EX2DR = 4'h0, UPDDR = 4'h5,
    SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA, EX1IR = 4'h9,
    PAUIR = 4'hB, EX2IR = 4'h8, UPDIR = 4'hD
  } tap_state_e;

  // All state lives in one packed record so TMR can wrap it uniformly.
  typedef struct packed {
    logic                tck_s1;
    logic                tck_s2;
    logic                tck_prev;
    logic                tms_s1;
    logic                tms_s2;
    logic                tdi_s1;
    logic                tdi_s2;
    logic [1:0]          fill;     // cycles since reset, saturates at 3
    logic                armed;    // synchronized TCK seen low after reset
    tap_state_e          state;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] ir_q;
    logic [31:0]         dr_id;
    logic [15:0]         dr_user;
    logic                dr_byp;
    logic                tdo;
    logic                tdo_oe;
    logic [15:0]         user_out;
    logic                upd_stb;
  } regs_t;

  localparam int                  W          = $bits(regs_t);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(2);

  function automatic regs_t f_reset_val();
    regs_t v;
    v       = '0;
    v.state = TLR;
    v.ir_q  = IR_IDCODE;
    return v;
  endfunction

  // Bitwise 2-of-3 majority.
  function automatic logic [W-1:0] f_vote(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  localparam regs_t RESET_VAL = f_reset_val();

  regs_t      w_q;
  regs_t      w_d;
  tap_state_e w_state_nxt;
  logic       w_rise;
  logic       w_fall;
  logic       w_sel_id;
  logic       w_sel_user;
  logic       w_dr_lsb;
  logic       w_in_shift;

  generate
    if (TMR) begin : g_tmr
      regs_t r_q0;
      regs_t r_q1;
      regs_t r_q2;
      // Three identical copies; the voted value feeds back so a single upset self-heals.
      always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
          r_q0 <= RESET_VAL;
          r_q1 <= RESET_VAL;
          r_q2 <= RESET_VAL;
        end else begin
          r_q0 <= w_d;
          r_q1 <= w_d;
          r_q2 <= w_d;
        end
      end
      assign w_q = regs_t'(f_vote(r_q0, r_q1, r_q2));
    end else begin : g_plain
      regs_t r_q;
      // Single copy of the state record.
      always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
          r_q <= RESET_VAL;
        end else begin
          r_q <= w_d;
        end
      end
      assign w_q = r_q;
    end
  endgenerate

  // Edges are ignored until TCK has been seen low, so a TCK held high through reset release is not a rise.
  assign w_rise     = w_q.armed &  w_q.tck_s2 & ~w_q.tck_prev;
  assign w_fall     = w_q.armed & ~w_q.tck_s2 &  w_q.tck_prev;
  assign w_sel_id   = (w_q.ir_q == IR_IDCODE);
  assign w_sel_user = (w_q.ir_q == IR_USER);
  assign w_in_shift = (w_q.state == SHIR) || (w_q.state == SHDR);

  // LSB of the data register selected by the active instruction.
  always_comb begin
    w_dr_lsb = w_q.dr_byp;
    if (w_sel_id) begin
      w_dr_lsb = w_q.dr_id[0];
    end else if (w_sel_user) begin
      w_dr_lsb = w_q.dr_user[0];
    end else begin
      w_dr_lsb = w_q.dr_byp;
    end
  end

  // TAP next-state table, evaluated with synchronized TMS.
  always_comb begin
    w_state_nxt = TLR;
    case (w_q.state)
      TLR:     w_state_nxt = w_q.tms_s2 ? TLR   : RTI;
      RTI:     w_state_nxt = w_q.tms_s2 ? SELDR : RTI;
      SELDR:   w_state_nxt = w_q.tms_s2 ? SELIR : CAPDR;
      CAPDR:   w_state_nxt = w_q.tms_s2 ? EX1DR : SHDR;
      SHDR:    w_state_nxt = w_q.tms_s2 ? EX1DR : SHDR;
      EX1DR:   w_state_nxt = w_q.tms_s2 ? UPDDR : PAUDR;
      PAUDR:   w_state_nxt = w_q.tms_s2 ? EX2DR : PAUDR;
      EX2DR:   w_state_nxt = w_q.tms_s2 ? UPDDR : SHDR;
      UPDDR:   w_state_nxt = w_q.tms_s2 ? SELDR : RTI;
      SELIR:   w_state_nxt = w_q.tms_s2 ? TLR   : CAPIR;
      CAPIR:   w_state_nxt = w_q.tms_s2 ? EX1IR : SHIR;
      SHIR:    w_state_nxt = w_q.tms_s2 ? EX1IR : SHIR;
      EX1IR:   w_state_nxt = w_q.tms_s2 ? UPDIR : PAUIR;
      PAUIR:   w_state_nxt = w_q.tms_s2 ? EX2IR : PAUIR;
      EX2IR:   w_state_nxt = w_q.tms_s2 ? UPDIR : SHIR;
      UPDIR:   w_state_nxt = w_q.tms_s2 ? SELDR : RTI;
      default: w_state_nxt = TLR;
    endcase
  end

  // Next value of the whole state record: synchronizers, rise actions, fall actions.
  always_comb begin
    w_d         = w_q;
    w_d.upd_stb = 1'b0;

    w_d.tck_s1   = bus.TCK;
    w_d.tck_s2   = w_q.tck_s1;
    w_d.tck_prev = w_q.tck_s2;
    w_d.tms_s1   = bus.TMS;
    w_d.tms_s2   = w_q.tms_s1;
    w_d.tdi_s1   = bus.TDI;
    w_d.tdi_s2   = w_q.tdi_s1;

    // fill guarantees s2 reflects the pin, not the reset value, before arming.
    if (w_q.fill != 2'd3) begin
      w_d.fill = w_q.fill + 2'd1;
    end else begin
      w_d.fill = w_q.fill;
    end
    if ((w_q.fill == 2'd3) && !w_q.tck_s2) begin
      w_d.armed = 1'b1;
    end else begin
      w_d.armed = w_q.armed;
    end

    if (w_rise) begin
      w_d.state = w_state_nxt;
      case (w_q.state)
        CAPIR: w_d.ir_sr = IR_WIDTH'(1);
        SHIR:  w_d.ir_sr = {w_q.tdi_s2, w_q.ir_sr[IR_WIDTH-1:1]};
        CAPDR: begin
          if (w_sel_id) begin
            w_d.dr_id = IDCODE;
          end else if (w_sel_user) begin
            w_d.dr_user = bus.USER_IN;
          end else begin
            w_d.dr_byp = 1'b0;
          end
        end
        SHDR: begin
          if (w_sel_id) begin
            w_d.dr_id = {w_q.tdi_s2, w_q.dr_id[31:1]};
          end else if (w_sel_user) begin
            w_d.dr_user = {w_q.tdi_s2, w_q.dr_user[15:1]};
          end else begin
            w_d.dr_byp = w_q.tdi_s2;
          end
        end
        default: w_d.ir_sr = w_q.ir_sr;
      endcase
      if (w_state_nxt == TLR) begin
        w_d.ir_q = IR_IDCODE;
      end else begin
        w_d.ir_q = w_q.ir_q;
      end
    end else if (w_fall) begin
      w_d.tdo_oe = w_in_shift;
      if (w_q.state == SHIR) begin
        w_d.tdo = w_q.ir_sr[0];
      end else if (w_q.state == SHDR) begin
        w_d.tdo = w_dr_lsb;
      end else begin
        w_d.tdo = 1'b0;
      end
      if (w_q.state == UPDIR) begin
        w_d.ir_q = w_q.ir_sr;
      end else if ((w_q.state == UPDDR) && w_sel_user) begin
        w_d.user_out = w_q.dr_user;
        w_d.upd_stb  = 1'b1;
      end else begin
        w_d.ir_q = w_q.ir_q;
      end
    end else begin
      w_d.state = w_q.state;
    end
  end

  assign bus.TDO        = w_q.tdo;
  assign bus.TDO_OE     = w_q.tdo_oe;
  assign bus.USER_OUT   = w_q.user_out;
  assign bus.UPDATE_STB = w_q.upd_stb;
  assign bus.TAP_STATE  = w_q.state;
  assign bus.IR_Q       = w_q.ir_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
module tb_jtag_tap_slave;

  logic FASTCLK;
  logic RST_B;
  int   n_checks;
  int   n_fail;
  int   n_stb;
  logic q_tdo[$];

  jtag_tap_slave_if #(.IR_WIDTH(8)) bus ();

  jtag_tap_slave #(.IR_WIDTH(8), .IDCODE(32'h0DB70001), .TMR(1'b0)) dut (
    .FASTCLK (FASTCLK),
    .RST_B   (RST_B),
    .bus     (bus)
  );

  initial FASTCLK = 1'b0;
  always #5 FASTCLK = ~FASTCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // UPDATE_STB high-cycle counter: a one-cycle pulse adds exactly 1.
  always @(posedge FASTCLK) begin
    if (bus.UPDATE_STB === 1'b1) n_stb <= n_stb + 1;
  end

  // Scoreboard monitor: after each TCK fall, pop and compare one bit while TDO_OE.
  always begin
    @(negedge bus.TCK);
    repeat (6) @(negedge FASTCLK);
    if (bus.TDO_OE === 1'b1) begin
      if (q_tdo.size() == 0) begin
        chk("tdo_unexpected_oe", 32'(bus.TDO_OE), 32'h0);
      end else begin
        chk("tdo_bit", 32'(bus.TDO), 32'(q_tdo.pop_front()));
      end
    end else begin
      chk("tdo_idle_zero", 32'(bus.TDO), 32'h0);
    end
  end

  task automatic sb_push(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) q_tdo.push_back(v[i]);
  endtask

  task automatic tck_cycle(input logic tms, input logic tdi);
    bus.TMS = tms;
    bus.TDI = tdi;
    repeat (2) @(negedge FASTCLK);
    bus.TCK = 1'b1;
    repeat (5) @(negedge FASTCLK);
    bus.TCK = 1'b0;
    repeat (8) @(negedge FASTCLK);
  endtask

  // Applies bits[0] first.
  task automatic tms_seq(input int n, input logic [7:0] bits);
    for (int i = 0; i < n; i++) tck_cycle(bits[i], 1'b0);
  endtask

  // n shift cycles, TMS=1 on the last to exit to Exit1.
  task automatic shift_bits(input int n, input logic [31:0] din);
    for (int i = 0; i < n; i++) tck_cycle(i == n - 1, din[i]);
  endtask

  task automatic load_ir(input logic [7:0] ir);
    sb_push(8, 32'h01);
    tms_seq(5, 8'b0000_0110);
    shift_bits(8, {24'h0, ir});
    tms_seq(2, 8'b0000_0001);
    chk("ir_q_after_upd", 32'(bus.IR_Q), {24'h0, ir});
    chk("ir_queue_drained", 32'(q_tdo.size()), 32'h0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},    32'(bus.TAP_STATE),  32'hF);
    chk({tag, "_ir_q"},     32'(bus.IR_Q),       32'h01);
    chk({tag, "_tdo"},      32'(bus.TDO),        32'h0);
    chk({tag, "_tdo_oe"},   32'(bus.TDO_OE),     32'h0);
    chk({tag, "_user_out"}, 32'(bus.USER_OUT),   32'h0);
    chk({tag, "_stb"},      32'(bus.UPDATE_STB), 32'h0);
  endtask

  logic [7:0] byp_din;
  logic [7:0] byp_exp;
  int         stb0;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_stb    = 0;
    RST_B    = 1'b0;
    bus.TCK  = 1'b1;
    bus.TMS  = 1'b0;
    bus.TDI  = 1'b0;
    bus.USER_IN = 16'h0000;
    repeat (5) @(negedge FASTCLK);
    chk_reset_values("por");

    // TCK high across reset release must not be taken as a rise.
    RST_B = 1'b1;
    repeat (10) @(negedge FASTCLK);
    chk("no_rise_before_low", 32'(bus.TAP_STATE), 32'hF);
    bus.TCK = 1'b0;
    repeat (8) @(negedge FASTCLK);
    chk("no_fall_action", 32'(bus.TAP_STATE), 32'hF);

    // Walk to Capture-DR, then five TMS=1 rises back to TLR.
    tms_seq(3, 8'b0000_0010);
    chk("state_capdr", 32'(bus.TAP_STATE), 32'h6);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    chk("tlr_after_5", 32'(bus.TAP_STATE), 32'hF);
    tck_cycle(1'b0, 1'b0);
    chk("rti_after_6", 32'(bus.TAP_STATE), 32'hC);

    // IDCODE read.
    sb_push(32, 32'h0DB70001);
    tms_seq(5, 8'b0000_0100);
    chk("state_shdr", 32'(bus.TAP_STATE), 32'h2);
    shift_bits(32, 32'h0);
    tms_seq(2, 8'b0000_0001);
    chk("idcode_final_rti", 32'(bus.TAP_STATE), 32'hC);
    chk("idcode_queue_drained", 32'(q_tdo.size()), 32'h0);

    // IR load of USER, then USER write/read.
    load_ir(8'h02);
    bus.USER_IN = 16'hA5C3;
    stb0 = n_stb;
    sb_push(16, 32'h0000A5C3);
    tms_seq(5, 8'b0000_0100);
    shift_bits(16, 32'h00001234);
    tms_seq(2, 8'b0000_0001);
    chk("user_out", 32'(bus.USER_OUT), 32'h1234);
    chk("user_stb_count", 32'(n_stb - stb0), 32'h1);
    chk("user_queue_drained", 32'(q_tdo.size()), 32'h0);

    // Unknown instruction falls back to 1-bit BYPASS: TDI echoed one TCK later.
    load_ir(8'h55);
    byp_din = 8'hB2;
    byp_exp = 8'h64;
    sb_push(8, {24'h0, byp_exp});
    tms_seq(5, 8'b0000_0100);
    shift_bits(8, {24'h0, byp_din});
    tms_seq(2, 8'b0000_0001);
    chk("bypass_queue_drained", 32'(q_tdo.size()), 32'h0);

    // TLR restores IDCODE as the active instruction.
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    chk("tlr_ir_idcode", 32'(bus.IR_Q), 32'h01);
    tck_cycle(1'b0, 1'b0);

    // IDCODE read with a Pause-DR in the middle; no recapture on resume.
    sb_push(32, 32'h0DB70001);
    tms_seq(5, 8'b0000_0100);
    shift_bits(16, 32'h0);
    tms_seq(2, 8'b0000_0000);
    chk("state_paudr", 32'(bus.TAP_STATE), 32'h3);
    tms_seq(2, 8'b0000_0001);
    chk("state_resume_shdr", 32'(bus.TAP_STATE), 32'h2);
    shift_bits(16, 32'h0);
    tms_seq(2, 8'b0000_0001);
    chk("pause_queue_drained", 32'(q_tdo.size()), 32'h0);

    // Reset asserted mid Shift-DR.
    sb_push(4, 32'h1);
    tms_seq(5, 8'b0000_0100);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1);
    chk("pre_reset_oe", 32'(bus.TDO_OE), 32'h1);
    stb0 = n_stb;
    @(negedge FASTCLK);
    RST_B = 1'b0;
    #1;
    chk_reset_values("midshift");
    repeat (4) @(negedge FASTCLK);
    RST_B = 1'b1;
    repeat (6) @(negedge FASTCLK);
    chk("midshift_no_stb", 32'(n_stb - stb0), 32'h0);
    chk("midshift_queue_drained", 32'(q_tdo.size()), 32'h0);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    chk("post_reset_rti", 32'(bus.TAP_STATE), 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_slave.md
JTAG_TAP_SLAVE -- requirements
Module: jtag_tap_slave

Interface
REQ-001 Parameter IR_WIDTH, default 8, instruction register length (≥2).
REQ-002 Parameter IDCODE, default 32'h0DB70001, value captured by the IDCODE instruction.
REQ-003 Parameter TMR, default 0, selects triplicated registers (1) or plain registers (0); TMR does not change function.
REQ-004 FASTCLK  in  1  sole clock; all flops are rising-edge FASTCLK.
REQ-005 RST_B  in  1  asynchronous, active-low reset.
REQ-006 TCK  in  1  JTAG clock, asynchronous to FASTCLK, sampled as data.
REQ-007 TMS  in  1  JTAG mode select.
REQ-008 TDI  in  1  JTAG serial data in.
REQ-009 USER_IN  in  16  parallel value captured into the USER data register.
REQ-010 TDO  out  1  JTAG serial data out.
REQ-011 TDO_OE  out  1  high while TDO is valid (Shift-DR/Shift-IR).
REQ-012 USER_OUT  out  16  USER register value latched at Update-DR.
REQ-013 UPDATE_STB  out  1  one-FASTCLK pulse when USER_OUT is loaded.
REQ-014 TAP_STATE  out  4  current TAP state code (REQ-019).
REQ-015 IR_Q  out  IR_WIDTH  active instruction.

Function
REQ-016 TCK, TMS and TDI each pass through a 2-flop FASTCLK synchronizer; a third TCK flop provides edge detection: rise = sync & ~prev; fall = ~sync & prev.
REQ-017 TCK high and low times are each ≥3 FASTCLK periods; behaviour for faster TCK is undefined.
REQ-018 TAP state advances only on the detected TCK rise, per IEEE 1149.1 using synchronized TMS.
REQ-019 State codes: TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D.
REQ-020 Five consecutive TCK rises with TMS=1 reach TLR from any state.
REQ-021 Instructions: 8'h01 IDCODE (32-bit DR), 8'h02 USER (16-bit DR), all-ones BYPASS (1-bit DR); any other code selects BYPASS.
REQ-022 On the rise that leaves CapIR, the IR shift register loads {0...0,01}; on the rise that leaves CapDR, the selected DR loads IDCODE, USER_IN, or 0 (BYPASS).
REQ-023 On each rise while in ShIR or ShDR, the selected register shifts right with TDI entering at the MSB; the rise that exits to Ex1 also shifts.
REQ-024 On TCK fall, TDO loads LSB of the selected shift register and TDO_OE is set in ShIR/ShDR and cleared otherwise; TDO is 0 whenever TDO_OE=0.
REQ-025 On TCK fall in UpdIR, IR_Q loads the IR shift register.
REQ-026 On TCK fall in UpdDR with USER selected, USER_OUT loads the USER shift register and UPDATE_STB pulses for exactly one FASTCLK.
REQ-027 Entering TLR (by TMS or reset) sets IR_Q to IDCODE (8'h01, zero-extended).
REQ-028 Pause states hold all shift contents; Ex2 -> Shift resumes without recapture.
REQ-029 Output latency: TDO/TDO_OE change ≤4 FASTCLK after the TCK pin falls.
REQ-030 TMS/TDI are sampled on the same FASTCLK cycle the rise is detected (setup relative to TCK is ≥1 FASTCLK).

Reset
REQ-031 RST_B low, at any time including mid-shift: state TLR (F), IR_Q=8'h01, all shift registers 0, USER_OUT 16'h0000, UPDATE_STB 0, TDO 0, TDO_OE 0, synchronizer flops 0.
REQ-032 After RST_B deasserts, no TCK edge is recognised until the synchronized TCK has been observed low at least once.

Verification
REQ-033 Reset: TMS sequence 1,1,1,1,1,0 from arbitrary state -> TAP_STATE F after fifth rise, C after sixth.
REQ-034 IDCODE read: RTI, header TMS 0,0,1,0,0, 32 shifts (last with TMS=1), tail 1,0 -> TDO serial LSB-first = 32'h0DB70001, final state C.
REQ-035 IR load: header 0,1,1,0,0, shift 8'h02 LSB-first, tail 1,0 -> TDO shows 01 then zeros, IR_Q=8'h02 after UpdIR.
REQ-036 USER write/read: USER_IN=16'hA5C3, IR=02, shift in 16'h1234 -> TDO returns 16'hA5C3, USER_OUT=16'h1234, one UPDATE_STB pulse.
REQ-037 Unknown IR 8'h55 -> 1-bit BYPASS: TDI pattern returned on TDO delayed by one TCK.
REQ-038 RST_B pulsed low mid ShDR -> all REQ-031 values immediately, USER_OUT unchanged from 0, no UPDATE_STB.
